tri_raster_scan: RTL and testbench
==================================

Name: tri_raster_scan

Overview:
- Upstream feeder for the triangle point-inclusion tester.
- On `start`, latches three vertices and computes twice the triangle area as an absolute value.
- Computes the vertex bounding box, clipped to the screen.
- Streams every pixel coordinate inside that box to the tester over a valid/ready handshake, column-major: py inner loop, px outer loop.
- Holds `area2` stable for the whole scan so the tester compares its three sub-areas against it.

Parameters:
- COORD_W, 9: width of every vertex and pixel coordinate, unsigned.
- X_MAX, 319: last valid screen column; bounding box clipped to it.
- Y_MAX, 239: last valid screen row; bounding box clipped to it.
- AREA_W, 2*COORD_W+2: width of `area2` (derived; do not override).

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ax, ay, bx, by, cx, cy  in  COORD_W each  vertex coordinates, sampled with `start`.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle pulse in DONE.
- degenerate  out  1  high when area2==0; valid from first SCAN/DONE cycle until next start.
- area2  out  AREA_W  |ax(by-cy)+bx(cy-ay)+cx(ay-by)|, held until next start.
- out_valid  out  1  pixel coordinate valid.
- out_ready  in  1  downstream accepts the pixel.
- px, py  out  COORD_W each  current pixel.
- out_last  out  1  high with the final pixel of the box.

Behaviour:
Reset:
- RESET_N low forces, immediately: state=IDLE; busy, done, degenerate, out_valid, out_last = 0; area2, px, py = 0.
- Reset mid-scan abandons the scan; no done pulse is produced.

States: IDLE -> SETUP1 -> SETUP2 -> SCAN -> DONE -> IDLE.
- IDLE:
  - start=1 latches the vertices; next state SETUP1.
  - start is ignored in every other state.
- SETUP1:
  - Register xmin/xmax/ymin/ymax = min/max over the three vertices.
  - Register the three signed products, each (COORD_W+1)-bit signed difference times zero-extended coordinate, into AREA_W signed.
- SETUP2:
  - Sum the three products, take the absolute value, and register it to `area2`.
  - Clip: xmax_c = min(xmax, X_MAX), ymax_c = min(ymax, Y_MAX).
  - Load px=xmin, py=ymin.
  - Box is empty if xmin>X_MAX or ymin>Y_MAX.
  - If area2==0 or the box is empty, next state is DONE (zero pixels emitted); otherwise SCAN.
- SCAN:
  - out_valid=1 from the first SCAN cycle. Latency: start accepted at cycle 0, first out_valid at cycle 3.
  - px, py and out_last stay stable while out_valid && !out_ready.
  - On handshake (out_valid && out_ready):
    - if py<ymax_c: py+1;
    - else py=ymin, px+1;
    - if px==xmax_c && py==ymax_c (`out_last`=1): out_valid drops next cycle; next state DONE.
  - Throughput: one pixel per cycle when out_ready is held high.
  - out_last = (px==xmax_c && py==ymax_c) && out_valid.
- DONE:
  - done=1 for one cycle, out_valid=0; next state IDLE.
  - busy drops entering IDLE.
  - start presented during DONE is ignored.

Arithmetic and boundaries:
- Coordinates are unsigned; the per-term difference is signed COORD_W+1 bits.
- No overflow for any COORD_W inputs at AREA_W.
- A vertex exactly at X_MAX/Y_MAX is inside the box.
- A single-pixel box (after clipping) is legal; that pixel is emitted with out_last=1.
- Counters never wrap past xmax_c/ymax_c.

Test Plan:
- Scalene triangle, A(12,5) B(5,16) C(2,2), out_ready=1:
  - area2=131, degenerate=0.
  - First pixel (2,2) at cycle 3, second (2,3).
  - 165 handshakes; last (12,16) with out_last=1.
  - done pulses exactly one cycle later.
- Same triangle, out_ready toggled with pattern 1,0,0,1 repeating:
  - Pixel sequence identical to the previous case, with no drops or repeats.
  - px/py stable during every stall cycle.
- Collinear vertices (0,0),(4,4),(8,8) -> area2=0, degenerate=1, no out_valid, done at cycle 3.
- Clipping, X_MAX=319: A(300,10) B(400,10) C(300,12) -> px spans 300..319, py 10..12, 60 pixels, last (319,12).
- Off-screen, all x >= 320 -> no out_valid, degenerate=0, done pulses.
- RESET_N low mid-scan at pixel (5,7):
  - All outputs clear immediately.
  - No done pulse.
  - A new start afterwards reruns from (xmin,ymin) with correct area2.

Source files
------------

// File: rtl/tri_raster_scan.sv
// rtl/tri_raster_scan.sv - triangle bounding-box raster scanner feeding the point-inclusion tester
module tri_raster_scan #(
  parameter int COORD_W = 9,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int AREA_W  = 2*COORD_W+2
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               busy,
  output logic               done,
  output logic               degenerate,
  output logic [AREA_W-1:0]  area2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               out_last
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SETUP1, S_SETUP2, S_SCAN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  logic [COORD_W-1:0] ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q, xmin_d, xmax_d, ymin_d, ymax_d;
  logic [COORD_W-1:0] xmax_c_q, ymax_c_q, xmax_c_d, ymax_c_d;
  logic [COORD_W-1:0] px_q, py_q, px_d, py_d;
  logic signed [AREA_W-1:0] prod_a_q, prod_b_q, prod_c_q, prod_a_d, prod_b_d, prod_c_d;
  logic signed [AREA_W-1:0] area_sum;
  logic [AREA_W-1:0] area2_q, area2_d;
  logic degenerate_q, degenerate_d;
  logic at_last, box_empty;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // One cross-product term: zero-extended coordinate times signed coordinate difference.
  function automatic logic signed [AREA_W-1:0] term(input logic [COORD_W-1:0] c, p, q);
    logic signed [COORD_W:0]   diff;
    logic signed [AREA_W-1:0]  c_s;
    diff = $signed({1'b0, p}) - $signed({1'b0, q});
    c_s  = $signed({{(AREA_W-COORD_W){1'b0}}, c});
    return c_s * AREA_W'(diff);
  endfunction

  assign area_sum   = prod_a_q + prod_b_q + prod_c_q;
  assign box_empty  = (xmin_q > X_LIM) || (ymin_q > Y_LIM);
  assign at_last    = (px_q == xmax_c_q) && (py_q == ymax_c_q);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = (state_q == S_SCAN);
  assign out_last   = out_valid && at_last;
  assign degenerate = degenerate_q;
  assign area2      = area2_q;
  assign px         = px_q;
  assign py         = py_q;

  // Next-state and datapath updates for the setup pipeline and column-major scan.
  always_comb begin
    state_d      = state_q;
    ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q; cx_d = cx_q; cy_d = cy_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
    xmax_c_d = xmax_c_q; ymax_c_d = ymax_c_q;
    px_d = px_q; py_d = py_q;
    prod_a_d = prod_a_q; prod_b_d = prod_b_q; prod_c_d = prod_c_q;
    area2_d      = area2_q;
    degenerate_d = degenerate_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ax_d = ax; ay_d = ay; bx_d = bx; by_d = by; cx_d = cx; cy_d = cy;
          state_d = S_SETUP1;
        end
      end
      S_SETUP1: begin
        xmin_d   = min3(ax_q, bx_q, cx_q);
        xmax_d   = max3(ax_q, bx_q, cx_q);
        ymin_d   = min3(ay_q, by_q, cy_q);
        ymax_d   = max3(ay_q, by_q, cy_q);
        prod_a_d = term(ax_q, by_q, cy_q);
        prod_b_d = term(bx_q, cy_q, ay_q);
        prod_c_d = term(cx_q, ay_q, by_q);
        state_d  = S_SETUP2;
      end
      S_SETUP2: begin
        area2_d      = $unsigned(area_sum[AREA_W-1] ? -area_sum : area_sum);
        degenerate_d = (area_sum == '0);
        xmax_c_d     = (xmax_q > X_LIM) ? X_LIM : xmax_q;
        ymax_c_d     = (ymax_q > Y_LIM) ? Y_LIM : ymax_q;
        px_d         = xmin_q;
        py_d         = ymin_q;
        state_d      = ((area_sum == '0) || box_empty) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_DONE;
          end else if (py_q < ymax_c_q) begin
            py_d = py_q + 1'b1;
          end else begin
            py_d = ymin_q;
            px_d = px_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by RESET_N.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
      xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      xmax_c_q <= '0; ymax_c_q <= '0;
      px_q <= '0; py_q <= '0;
      prod_a_q <= '0; prod_b_q <= '0; prod_c_q <= '0;
      area2_q <= '0;
      degenerate_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d; cx_q <= cx_d; cy_q <= cy_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      xmax_c_q <= xmax_c_d; ymax_c_q <= ymax_c_d;
      px_q <= px_d; py_q <= py_d;
      prod_a_q <= prod_a_d; prod_b_q <= prod_b_d; prod_c_q <= prod_c_d;
      area2_q <= area2_d;
      degenerate_q <= degenerate_d;
    end
  end

endmodule

// File: tb/tb_tri_raster_scan.sv
// tb/tb_tri_raster_scan.sv - scoreboard bench for tri_raster_scan
module tb_tri_raster_scan;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [8:0]  ax, ay, bx, by, cx, cy;
  logic        busy, done, degenerate, out_valid, out_ready, out_last;
  logic [19:0] area2;
  logic [8:0]  px, py;

  int passed = 0;
  int total  = 0;

  // Expected pixel stream: {px, py, last}
  logic [18:0] sb[$];

  logic        prev_stall = 1'b0;
  logic [18:0] prev_pix   = '0;

  tri_raster_scan dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .busy(busy), .done(done), .degenerate(degenerate), .area2(area2),
    .out_valid(out_valid), .out_ready(out_ready),
    .px(px), .py(py), .out_last(out_last)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (out_valid && {px, py, out_last} == prev_pix) passed++;
        else $display("FAIL stall_hold: got v=%0d (%0d,%0d) last=%0d expected (%0d,%0d) last=%0d",
                      out_valid, px, py, out_last, prev_pix[18:10], prev_pix[9:1], prev_pix[0]);
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL pixel: got (%0d,%0d) last=%0d expected no pixel", px, py, out_last);
        end else begin
          logic [18:0] e;
          e = sb.pop_front();
          if ({px, py, out_last} == e) passed++;
          else $display("FAIL pixel: got (%0d,%0d) last=%0d expected (%0d,%0d) last=%0d",
                        px, py, out_last, e[18:10], e[9:1], e[0]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = {px, py, out_last};
    end
  end

  // Builds the expected pixel list and issues start; returns at the cycle-1 boundary.
  task automatic issue(input int xa, ya, xb, yb, xc, yc, input int exp_area);
    int x0, x1, y0, y1;
    x0 = (xa < xb) ? xa : xb; x0 = (xc < x0) ? xc : x0;
    x1 = (xa > xb) ? xa : xb; x1 = (xc > x1) ? xc : x1;
    y0 = (ya < yb) ? ya : yb; y0 = (yc < y0) ? yc : y0;
    y1 = (ya > yb) ? ya : yb; y1 = (yc > y1) ? yc : y1;
    if (x1 > 319) x1 = 319;
    if (y1 > 239) y1 = 239;
    if (exp_area != 0 && x0 <= 319 && y0 <= 239)
      for (int x = x0; x <= x1; x++)
        for (int y = y0; y <= y1; y++)
          sb.push_back({9'(x), 9'(y), (x == x1 && y == y1)});
    ax = 9'(xa); ay = 9'(ya); bx = 9'(xb); by = 9'(yb); cx = 9'(xc); cy = 9'(yc);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int xa, ya, xb, yb, xc, yc,
                     input int exp_area, input int exp_deg, input bit stall);
    logic [3:0] pat;
    int cyc, first, lastcyc, donecyc, ndone, hs, npix;
    pat = 4'b1001;
    out_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    issue(xa, ya, xb, yb, xc, yc, exp_area);
    npix = sb.size();
    cyc = 1; first = -1; lastcyc = -1; donecyc = -1; ndone = 0; hs = 0;
    while (cyc < 1000 && (donecyc < 0 || cyc <= donecyc + 1)) begin
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      if (cyc == 2) start = 1'b1;  // start outside IDLE must be ignored
      @(negedge CLOCK_50);
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        hs++;
        if (out_last) lastcyc = cyc;
      end
      if (done) begin
        ndone++;
        if (donecyc < 0) donecyc = cyc;
        start = 1'b1;              // and during DONE as well
      end
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_seen"}, donecyc >= 0, 1);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_handshakes"}, hs, npix);
    check({tag, "_sb_empty"}, sb.size(), 0);
    if (npix > 0) begin
      check({tag, "_first_cycle"}, first, 3);
      check({tag, "_done_after_last"}, donecyc, lastcyc + 1);
    end else begin
      check({tag, "_no_valid"}, first, -1);
      check({tag, "_done_cycle"}, donecyc, 3);
    end
    check({tag, "_area2"}, area2, exp_area);
    check({tag, "_degenerate"}, degenerate, exp_deg);
    check({tag, "_idle_busy"}, busy, 0);
    sb.delete();
  endtask

  initial begin
    int n;
    RESET_N = 1'b0; start = 1'b0; out_ready = 1'b1;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_flags", {busy, done, degenerate, out_valid, out_last}, 0);
    check("rst_area2", area2, 0);
    check("rst_pixel", {px, py}, 0);
    RESET_N = 1'b1;

    run("scalene",   12, 5, 5, 16, 2, 2, 131, 0, 1'b0);
    run("stall",     12, 5, 5, 16, 2, 2, 131, 0, 1'b1);
    run("collinear", 0, 0, 4, 4, 8, 8, 0, 1, 1'b0);
    run("clip",      300, 10, 400, 10, 300, 12, 200, 0, 1'b0);
    run("offscreen", 320, 5, 400, 5, 320, 50, 3600, 0, 1'b0);
    run("corner",    319, 239, 400, 239, 319, 300, 4941, 0, 1'b0);

    // Reset in the middle of a scan at pixel (5,7)
    out_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    issue(12, 5, 5, 16, 2, 2, 131);
    n = 0;
    while (n < 200 && !(out_valid && px == 9'd5 && py == 9'd7)) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("mid_reached", n < 200, 1);
    #1 RESET_N = 1'b0;
    #1;
    check("mid_rst_flags", {busy, done, degenerate, out_valid, out_last}, 0);
    check("mid_rst_area2", area2, 0);
    check("mid_rst_pixel", {px, py}, 0);
    sb.delete();
    n = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (done) n++;
    end
    check("mid_rst_no_done", n, 0);
    RESET_N = 1'b1;
    run("rerun", 12, 5, 5, 16, 2, 2, 131, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
